// File: rtl/branch_predictor_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | branch_predictor_pkg : shared widths and 2-bit counter encodings      |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package branch_predictor_pkg;

    localparam int WORD_SIZE = 16;
    localparam int MISPRED_W = 16;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } ctr_e;

endpackage
`default_nettype wire

// File: rtl/branch_predictor_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | branch_predictor_if : fetch lookup and resolve/update signal bundle   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface branch_predictor_if #(
    parameter int WORD_SIZE = branch_predictor_pkg::WORD_SIZE
);
    logic [WORD_SIZE-1:0] PC;
    logic [WORD_SIZE-1:0] PredictedPC;
    logic                 PredTaken;
    logic                 UpdateEn;
    logic [WORD_SIZE-1:0] UpdatePC;
    logic [WORD_SIZE-1:0] UpdateTarget;
    logic                 UpdateIsJump;
    logic                 UpdateTaken;
    logic                 UpdateMispredict;
    logic [15:0]          MispredCount;

    modport master (
        output PC, UpdateEn, UpdatePC, UpdateTarget, UpdateIsJump,
               UpdateTaken, UpdateMispredict,
        input  PredictedPC, PredTaken, MispredCount
    );

    modport slave (
        input  PC, UpdateEn, UpdatePC, UpdateTarget, UpdateIsJump,
               UpdateTaken, UpdateMispredict,
        output PredictedPC, PredTaken, MispredCount
    );
endinterface
`default_nettype wire

// File: rtl/branch_predictor_sat_counter2.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sat_counter2 : combinational 2-bit saturating increment / decrement   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  ctr_e ctr_i,
    input  logic inc_i,
    output ctr_e ctr_o
);
    always_comb begin
        ctr_o = ctr_i;
        case (ctr_i)
            STRONG_NT: ctr_o = inc_i ? WEAK_NT  : STRONG_NT;
            WEAK_NT:   ctr_o = inc_i ? WEAK_T   : STRONG_NT;
            WEAK_T:    ctr_o = inc_i ? STRONG_T : WEAK_NT;
            STRONG_T:  ctr_o = inc_i ? STRONG_T : WEAK_T;
            default:   ctr_o = ctr_i;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | branch_predictor : direct-mapped BTB with 2-bit counters, FF storage  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module branch_predictor #(
    parameter int ENTRIES   = 16,
    parameter int WORD_SIZE = branch_predictor_pkg::WORD_SIZE
) (
    input  wire logic           clk,
    input  wire logic           reset_n,
    branch_predictor_if.slave   bus
);
    import branch_predictor_pkg::*;

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = WORD_SIZE - IDX_W;

    logic                 valid_q  [ENTRIES];
    logic [TAG_W-1:0]     tag_q    [ENTRIES];
    logic [WORD_SIZE-1:0] target_q [ENTRIES];
    ctr_e                 ctr_q    [ENTRIES];
    logic [MISPRED_W-1:0] mispred_q, mispred_d;

    logic [IDX_W-1:0] l_idx, u_idx;
    logic [TAG_W-1:0] l_tag, u_tag;
    logic             l_hit, u_hit;
    ctr_e             u_ctr_sat, wr_ctr;
    logic             wr_en, wr_tgt_en;

    // Lookup port: reads registered state only, so same-cycle updates are not bypassed
    assign l_idx = bus.PC[IDX_W-1:0];
    assign l_tag = bus.PC[WORD_SIZE-1:IDX_W];
    assign l_hit = valid_q[l_idx] && (tag_q[l_idx] == l_tag);

    assign bus.PredTaken    = l_hit && ctr_q[l_idx][1];
    assign bus.PredictedPC  = bus.PredTaken ? target_q[l_idx] : bus.PC + WORD_SIZE'(1);
    assign bus.MispredCount = mispred_q;

    assign u_idx = bus.UpdatePC[IDX_W-1:0];
    assign u_tag = bus.UpdatePC[WORD_SIZE-1:IDX_W];
    assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

    sat_counter2 u_sat (
        .ctr_i (ctr_q[u_idx]),
        .inc_i (bus.UpdateTaken),
        .ctr_o (u_ctr_sat)
    );

    always_comb begin
        wr_en     = 1'b0;
        wr_tgt_en = 1'b0;
        wr_ctr    = ctr_q[u_idx];
        if (bus.UpdateEn) begin
            if (bus.UpdateIsJump) begin
                wr_en     = 1'b1;
                wr_tgt_en = 1'b1;
                wr_ctr    = STRONG_T;
            end else if (u_hit) begin
                wr_en     = 1'b1;
                wr_tgt_en = bus.UpdateTaken;
                wr_ctr    = u_ctr_sat;
            end else if (bus.UpdateTaken) begin
                wr_en     = 1'b1;
                wr_tgt_en = 1'b1;
                wr_ctr    = WEAK_T;
            end
        end
    end

    always_comb begin
        mispred_d = mispred_q;
        if (bus.UpdateEn && bus.UpdateMispredict && (mispred_q != {MISPRED_W{1'b1}}))
            mispred_d = mispred_q + MISPRED_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= WEAK_NT;
            end
            mispred_q <= '0;
        end else begin
            if (wr_en) begin
                valid_q[u_idx] <= 1'b1;
                ctr_q[u_idx]   <= wr_ctr;
            end
            mispred_q <= mispred_d;
        end
    end

    // Tags and targets are don't-care while invalid, so they carry no reset
    always_ff @(posedge clk) begin
        if (reset_n && wr_en)
            tag_q[u_idx] <= u_tag;
        if (reset_n && wr_tgt_en)
            target_q[u_idx] <= bus.UpdateTarget;
    end
endmodule
`default_nettype wire

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter ENTRIES, default 16: number of BTB entries; power of two, 4..64.
REQ-002 Parameter WORD_SIZE, default 16: PC and target width in bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset, synchronous, active-low.
REQ-005 PC  input  WORD_SIZE  current IF-stage fetch address.
REQ-006 PredictedPC  output  WORD_SIZE  next fetch address chosen for PC.
REQ-007 PredTaken  output  1  prediction for PC is taken (BTB target used).
REQ-008 UpdateEn  input  1  resolved control-flow instruction presented this cycle.
REQ-009 UpdatePC  input  WORD_SIZE  address of the resolved instruction.
REQ-010 UpdateTarget  input  WORD_SIZE  resolved taken-target address.
REQ-011 UpdateIsJump  input  1  resolved instruction is JMP/JAL/JPR/JRL; 0 = conditional branch.
REQ-012 UpdateTaken  input  1  actual branch outcome; ignored when UpdateIsJump=1.
REQ-013 UpdateMispredict  input  1  the resolved instruction was mispredicted (drives flush in Control).
REQ-014 MispredCount  output  16  saturating count of mispredictions since reset.

Function
REQ-015 Index = PC[log2(ENTRIES)-1:0]; tag = remaining upper PC bits; each entry holds valid, tag, target, 2-bit counter.
REQ-016 Lookup SHALL be combinational: hit = valid & tag match; PredTaken = hit & counter[1]; PredictedPC = PredTaken ? target : PC+1 (modulo 2^WORD_SIZE; 0xFFFF wraps to 0x0000).
REQ-017 Update SHALL occur only on a clock edge with UpdateEn=1 and reset_n=1; result is visible to lookup on the following cycle (one-cycle write latency).
REQ-018 Jump update: entry at UpdatePC index SHALL be written valid, tag, target=UpdateTarget, counter=2'b11, regardless of prior contents.
REQ-019 Branch update, hit: counter SHALL saturating-increment if UpdateTaken else saturating-decrement (limits 2'b00 and 2'b11); target overwritten with UpdateTarget only when UpdateTaken=1.
REQ-020 Branch update, miss (invalid or tag mismatch), UpdateTaken=1: entry SHALL be allocated (replacing any occupant) with counter=2'b10 and target=UpdateTarget.
REQ-021 Branch update, miss, UpdateTaken=0: no entry SHALL change.
REQ-022 Same-cycle lookup and update to the same index: lookup SHALL return pre-update contents (no write-through bypass).
REQ-023 MispredCount SHALL increment by 1 on each edge with UpdateEn=1 and UpdateMispredict=1, holding at 16'hFFFF; UpdateMispredict with UpdateEn=0 is ignored.
REQ-024 Stall and flush in the pipeline SHALL NOT be seen by this block; the caller deasserts UpdateEn for squashed instructions.

Reset
REQ-025 On an edge with reset_n=0: all valid bits cleared, all counters set to 2'b01, MispredCount=0; tags and targets need not be cleared.
REQ-026 While reset_n=0, UpdateEn SHALL be ignored; the output after reset is PredTaken=0, PredictedPC=PC+1 for every PC.
REQ-027 Reset asserted mid-operation SHALL take priority over a simultaneous update.

Structure
REQ-028 Shared package (with the opcode/func constants): WORD_SIZE, counter encodings (STRONG_NT=00, WEAK_NT=01, WEAK_T=10, STRONG_T=11).
REQ-029 One sub-module, sat_counter2: combinational 2-bit saturating inc/dec, instantiated once on the update path.
REQ-030 Storage SHALL be flip-flop arrays (no RAM macro); one update port, one lookup port.

Verification
REQ-031 Reset, then PC=0x0010 -> PredTaken=0, PredictedPC=0x0011; MispredCount=0.
REQ-032 Branch update PC=0x0012, Taken=1, Target=0x0040; next cycle PC=0x0012 -> PredTaken=1, PredictedPC=0x0040; two not-taken updates -> PredTaken=0 (counter 10->01->00).
REQ-033 Jump update PC=0x0025, Target=0x0100; then PC=0x0035 (same index, different tag) -> miss, PredictedPC=0x0036; PC=0x0025 -> 0x0100.
REQ-034 Same-cycle update (PC=0x0007, Taken=1, Target=0x0200) and lookup PC=0x0007 on an empty entry -> PredTaken=0 that cycle, 1 next cycle.
REQ-035 PC=0xFFFF on an empty BTB -> PredictedPC=0x0000; 65537 UpdateEn+UpdateMispredict pulses -> MispredCount=16'hFFFF.
REQ-036 Populate 3 entries, assert reset_n=0 for one edge concurrently with UpdateEn=1 -> all lookups miss afterwards, MispredCount=0.
